// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller command port between two requesters
// (port 0: CPU, port 1: DMA/display) and schedules periodic auto-refresh,
// which always wins over both ports. One transaction is in flight at a time.
//
// Configuration macro: SDRAM_ARB_FIXED_PRIO_EN
//   defined   : port 0 always wins a tie between eligible ports
//   undefined : round-robin between eligible ports (default)
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   p0_* / p1_*           requester ports: req/we/addr/wdata in, ack/rdata out
//   mem_req/we/addr/wdata registered command to the SDRAM controller
//   mem_ack, mem_rdata    command completion pulse and read data
//   mem_ref_req/ref_ack   auto-refresh handshake
//   ref_overrun           sticky: refresh interval expired with refresh pending
// ---------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REFRESH_CYCLES = 390
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ref_req,
  input  logic              mem_ref_ack,
  output logic              ref_overrun
);

  localparam int unsigned TMR_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_ref_pending;
  logic             r_winner;      // 1 = port 1 owns the in-flight transfer
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic             r_last_grant;
`endif

  logic w_tmr_zero;
  logic w_ref_done;
  logic w_p0_elig;
  logic w_p1_elig;
  logic w_pick1;

  assign w_tmr_zero = (r_timer == '0);
  assign w_ref_done = (r_state == ST_REFRESH) && mem_ref_ack;

  // A port in its ack cycle still shows the request it just completed.
  assign w_p0_elig = p0_req & ~p0_ack;
  assign w_p1_elig = p1_req & ~p1_ack;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign w_pick1 = w_p1_elig & ~w_p0_elig;
`else
  // On a tie, grant the port that did not win last time.
  assign w_pick1 = w_p1_elig & (~w_p0_elig | ~r_last_grant);
`endif

  // Refresh interval timer; a new expiry beats a same-cycle refresh ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer       <= TMR_RELOAD;
      r_ref_pending <= 1'b0;
      ref_overrun   <= 1'b0;
    end else if (w_tmr_zero) begin
      r_timer       <= TMR_RELOAD;
      r_ref_pending <= 1'b1;
      if (r_ref_pending && !w_ref_done) ref_overrun <= 1'b1;
    end else begin
      r_timer <= r_timer - TMR_W'(1);
      if (w_ref_done) r_ref_pending <= 1'b0;
    end
  end

  // Arbitration FSM with registered command and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_winner     <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_ref_req  <= 1'b0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_ref_pending) begin
            mem_ref_req <= 1'b1;
            r_state     <= ST_REFRESH;
          end else if (w_p0_elig || w_p1_elig) begin
            mem_req   <= 1'b1;
            r_winner  <= w_pick1;
            mem_we    <= w_pick1 ? p1_we    : p0_we;
            mem_addr  <= w_pick1 ? p1_addr  : p0_addr;
            mem_wdata <= w_pick1 ? p1_wdata : p0_wdata;
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (r_winner) begin
              p1_ack <= 1'b1;
              if (!mem_we) p1_rdata <= mem_rdata;
            end else begin
              p0_ack <= 1'b1;
              if (!mem_we) p0_rdata <= mem_rdata;
            end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            r_last_grant <= r_winner;
`endif
            r_state <= ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (mem_ref_ack) begin
            mem_ref_req <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. u_dut (long refresh interval) covers
// arbitration and data paths; u_ref (REFRESH_CYCLES=8) covers refresh timing.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;

  logic        mem_ack, m_ref_ack;
  logic        p0_ack, p1_ack, mem_req, mem_we, mem_ref_req, ref_overrun;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;

  logic        f_mem_ack, f_ref_ack;
  logic        f_p0_ack, f_p1_ack, f_mem_req, f_mem_we, f_mem_ref_req, f_ref_overrun;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(32), .DATA_W(32), .REFRESH_CYCLES(1000)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_ref_req(mem_ref_req), .mem_ref_ack(m_ref_ack), .ref_overrun(ref_overrun)
  );

  sdram_arbiter #(.ADDR_W(32), .DATA_W(32), .REFRESH_CYCLES(8)) u_ref (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_ack(f_mem_ack), .mem_rdata(mem_rdata),
    .mem_ref_req(f_mem_ref_req), .mem_ref_ack(f_ref_ack), .ref_overrun(f_ref_overrun)
  );

  typedef struct {
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, m_ack;
    logic        e_req, e_we, e_p0_ack, e_p1_ack;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
    mem_ack = 1'b0; f_mem_ack = 1'b0; f_ref_ack = 1'b0; m_ref_ack = 1'b0;
    mem_rdata = '0;
  endtask

  // Reset is released 1 time unit after an edge; the next edge is cycle 1.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    p0_addr = A0; p1_addr = A1;
    p0_wdata = 32'hDEAD_BEEF; p1_wdata = 32'h5555_AAAA;
    clear_inputs();

    // rst p0r p0w p1r p1w ack | req we p0a p1a addr
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, A0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, A1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, A1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, A1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A1};

    // Reset state
    do_reset();
    check("rst_cmd", 64'({mem_req, mem_we, mem_ref_req, ref_overrun, p0_ack, p1_ack}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));

    // Write latency, tie round-robin, stale-request masking, stray mem_ack
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst) do_reset();
      p0_req = tbl[i].p0_req; p0_we = tbl[i].p0_we;
      p1_req = tbl[i].p1_req; p1_we = tbl[i].p1_we;
      mem_ack = tbl[i].m_ack;
      tick();
      check($sformatf("vec%0d", i),
            64'({mem_req, mem_we, p0_ack, p1_ack, mem_addr}),
            64'({tbl[i].e_req, tbl[i].e_we, tbl[i].e_p0_ack, tbl[i].e_p1_ack, tbl[i].e_addr}));
      if (i == 0) check("wr_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    end

    // Read data routing and hold
    do_reset();
    p0_req = 1'b1;
    tick();
    mem_rdata = 32'h1234_5678; mem_ack = 1'b1;
    tick();
    check("p0_rd_ack", 64'(p0_ack), 64'(1));
    check("p0_rdata", 64'(p0_rdata), 64'(32'h1234_5678));
    p0_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0; p1_req = 1'b1;
    tick();
    tick();
    mem_rdata = 32'hCAFE_0001; mem_ack = 1'b1;
    tick();
    check("p1_rd_ack", 64'({p0_ack, p1_ack}), 64'(2'b01));
    check("p1_rdata", 64'(p1_rdata), 64'(32'hCAFE_0001));
    p1_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    tick();
    check("p1_rdata_hold", 64'(p1_rdata), 64'(32'hCAFE_0001));
    check("p0_rdata_keep", 64'(p0_rdata), 64'(32'h1234_5678));

    // Reset in the middle of a transfer
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    p0_req = 1'b0; p0_we = 1'b0; mem_ack = 1'b0;
    tick();
    p0_req = 1'b1; p1_req = 1'b1;
    tick();
    check("rr_before_rst", 64'({mem_req, mem_addr}), 64'({1'b1, A1}));
    #2 reset = 1'b0;
    #1 check("async_drop", 64'(mem_req), 64'(0));
    mem_ack = 1'b1;
    tick();
    tick();
    check("no_ack_in_rst", 64'({mem_req, p0_ack, p1_ack}), 64'(0));
    reset = 1'b1; mem_ack = 1'b0;
    tick();
    check("tie_after_rst", 64'({mem_req, p1_ack, mem_addr}), 64'({1'b1, 1'b0, A0}));

    // Refresh period, same-cycle expiry/ack, overrun (REFRESH_CYCLES=8)
    do_reset();
    run_until(8);
    check("ref_c8", 64'(f_mem_ref_req), 64'(0));
    tick();
    check("ref_c9", 64'(f_mem_ref_req), 64'(1));
    f_ref_ack = 1'b1;
    tick();
    f_ref_ack = 1'b0;
    check("ref_c10_drop", 64'(f_mem_ref_req), 64'(0));
    run_until(16);
    check("ref_c16", 64'(f_mem_ref_req), 64'(0));
    tick();
    check("ref_c17", 64'(f_mem_ref_req), 64'(1));
    run_until(23);
    f_ref_ack = 1'b1;
    tick();
    f_ref_ack = 1'b0;
    check("ref_same_cyc", 64'({f_mem_ref_req, f_ref_overrun}), 64'(0));
    tick();
    check("ref_kept_pend", 64'(f_mem_ref_req), 64'(1));
    run_until(31);
    check("ovr_c31", 64'(f_ref_overrun), 64'(0));
    tick();
    check("ovr_c32", 64'(f_ref_overrun), 64'(1));
    tick();
    f_ref_ack = 1'b1;
    tick();
    f_ref_ack = 1'b0;
    check("ref_c34_drop", 64'(f_mem_ref_req), 64'(0));
    run_until(40);
    check("ovr_sticky", 64'({f_ref_overrun, f_mem_req}), 64'(2'b10));

    // Refresh falls due during a transfer
    do_reset();
    run_until(4);
    p0_req = 1'b1; p1_req = 1'b1;
    tick();
    check("x_grant", 64'({f_mem_req, f_mem_addr}), 64'({1'b1, A0}));
    run_until(10);
    check("x_no_abort", 64'({f_mem_req, f_mem_ref_req}), 64'(2'b10));
    f_mem_ack = 1'b1;
    tick();
    f_mem_ack = 1'b0; p0_req = 1'b0;
    check("x_done", 64'({f_mem_req, f_p0_ack, f_mem_ref_req}), 64'(3'b010));
    tick();
    check("x_ref_first", 64'({f_mem_req, f_mem_ref_req}), 64'(2'b01));
    f_ref_ack = 1'b1;
    tick();
    f_ref_ack = 1'b0;
    tick();
    check("x_p1_after", 64'({f_mem_req, f_mem_ref_req, f_mem_addr}), 64'({2'b10, A1}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
